// File: rtl/track_ctrl.sv
// rtl/track_ctrl.sv - GNSS channel search/pull-in/track sequencer with epoch dump timing
// Optional TRACK_CTRL_STATS_EN adds the lock_epochs counter output.
module track_ctrl #(
    parameter int EPOCH_LEN    = 16368,
    parameter int THRESH_SHIFT = 3,
    parameter int PI_EPOCHS    = 20,
    parameter int LOSS_EPOCHS  = 50
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        stop,
    input  logic [4:0]  prn_in,
    input  logic        sample_valid,
    input  logic [31:0] corr_p_pow,
    input  logic [31:0] corr_noise,
    output logic        dump,
    output logic        code_step,
    output logic [4:0]  prn_select,
    output logic        loop_en,
    output logic        locked,
    output logic        fail,
`ifdef TRACK_CTRL_STATS_EN
    output logic [31:0] lock_epochs,
`endif
    output logic [2:0]  state
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEARCH  = 3'd1;
    localparam logic [2:0] S_PULL_IN = 3'd2;
    localparam logic [2:0] S_TRACK   = 3'd3;
    localparam logic [2:0] S_FAIL    = 3'd4;

    localparam logic [15:0] EPOCH_LAST = 16'(EPOCH_LEN - 1);
    localparam logic [7:0]  PI_N       = 8'(PI_EPOCHS);
    localparam logic [7:0]  PI_PASS    = 8'(PI_EPOCHS / 2);
    localparam logic [7:0]  LOSS_N     = 8'(LOSS_EPOCHS);
    localparam logic [10:0] STEP_LAST  = 11'd2045;

    logic [15:0] epoch_cnt;
    logic [10:0] step_cnt;
    logic [7:0]  win_cnt;
    logic [7:0]  hit_cnt;
    logic [7:0]  miss_cnt;
    logic        eval;

    logic [39:0] pow_ext;
    logic [39:0] thresh;
    logic        hit;
    logic        launch;
    logic [7:0]  win_next;
    logic [7:0]  hit_next;
    logic [7:0]  miss_next;
    logic        win_done;
    logic        pi_pass;
    logic        steps_exhausted;

    // Threshold is widened before the shift so large noise floors never wrap into a false hit.
    assign pow_ext         = {8'd0, corr_p_pow};
    assign thresh          = {8'd0, corr_noise} << THRESH_SHIFT;
    assign hit             = pow_ext > thresh;
    assign launch          = ((state == S_IDLE) || (state == S_FAIL)) && start && (prn_in != 5'd0);
    assign win_next        = win_cnt + 8'd1;
    assign hit_next        = hit_cnt + {7'd0, hit};
    assign miss_next       = miss_cnt + 8'd1;
    assign win_done        = (win_next == PI_N);
    assign pi_pass         = (hit_next >= PI_PASS);
    assign steps_exhausted = (step_cnt >= STEP_LAST);

    assign loop_en = (state == S_PULL_IN) || (state == S_TRACK);
    assign locked  = (state == S_TRACK);
    assign fail    = (state == S_FAIL);

    // code_step is issued in the eval cycle itself so the code generator slips before the next epoch.
    always_comb begin
        code_step = 1'b0;
        if (eval && !stop) begin
            case (state)
                S_SEARCH:  code_step = !hit && !steps_exhausted;
                S_PULL_IN: code_step = win_done && !pi_pass;
                default:   code_step = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            prn_select <= 5'd0;
            epoch_cnt  <= 16'd0;
            step_cnt   <= 11'd0;
            win_cnt    <= 8'd0;
            hit_cnt    <= 8'd0;
            miss_cnt   <= 8'd0;
            dump       <= 1'b0;
            eval       <= 1'b0;
        end else begin
            eval <= dump;
            dump <= 1'b0;
            if ((state != S_IDLE) && sample_valid) begin
                if (epoch_cnt == EPOCH_LAST) begin
                    epoch_cnt <= 16'd0;
                    dump      <= 1'b1;
                end else begin
                    epoch_cnt <= epoch_cnt + 16'd1;
                end
            end

            if (stop) begin
                state     <= S_IDLE;
                epoch_cnt <= 16'd0;
                dump      <= 1'b0;
                eval      <= 1'b0;
            end else if (launch) begin
                state      <= S_SEARCH;
                prn_select <= prn_in;
                epoch_cnt  <= 16'd0;
                step_cnt   <= 11'd0;
                win_cnt    <= 8'd0;
                hit_cnt    <= 8'd0;
                miss_cnt   <= 8'd0;
                dump       <= 1'b0;
                eval       <= 1'b0;
            end else if (eval) begin
                case (state)
                    S_SEARCH: begin
                        if (hit) begin
                            state   <= S_PULL_IN;
                            win_cnt <= 8'd0;
                            hit_cnt <= 8'd0;
                        end else if (steps_exhausted) begin
                            state <= S_FAIL;
                        end else begin
                            step_cnt <= step_cnt + 11'd1;
                        end
                    end
                    S_PULL_IN: begin
                        if (win_done) begin
                            if (pi_pass) begin
                                state    <= S_TRACK;
                                miss_cnt <= 8'd0;
                            end else begin
                                state    <= S_SEARCH;
                                step_cnt <= step_cnt + 11'd1;
                            end
                        end else begin
                            win_cnt <= win_next;
                            hit_cnt <= hit_next;
                        end
                    end
                    S_TRACK: begin
                        if (hit) begin
                            miss_cnt <= 8'd0;
                        end else if (miss_next == LOSS_N) begin
                            state    <= S_SEARCH;
                            step_cnt <= 11'd0;
                            miss_cnt <= 8'd0;
                        end else begin
                            miss_cnt <= miss_next;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef TRACK_CTRL_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lock_epochs <= 32'd0;
        end else if (!stop && launch) begin
            lock_epochs <= 32'd0;
        end else if (eval && (state == S_TRACK) && (lock_epochs != 32'hFFFF_FFFF)) begin
            lock_epochs <= lock_epochs + 32'd1;
        end
    end
`endif

endmodule

// File: doc/track_ctrl.md
TRACK_CTRL -- requirements
Module: track_ctrl

Interface
REQ-001 SHALL have parameter EPOCH_LEN, default 16368, samples per 1 ms integrate-and-dump epoch (range 2..65535).
REQ-002 SHALL have parameter THRESH_SHIFT, default 3, log2 of the detection margin over the noise floor.
REQ-003 SHALL have parameter PI_EPOCHS, default 20, pull-in window length in epochs (range 2..255).
REQ-004 SHALL have parameter LOSS_EPOCHS, default 50, consecutive missed epochs that declare loss of lock (range 1..255).
REQ-005 SHALL have port CLK  in  1  system clock, all state on rising edge.
REQ-006 SHALL have port RST  in  1  asynchronous active-high reset.
REQ-007 SHALL have port start  in  1  level; begins a search for prn_in.
REQ-008 SHALL have port stop  in  1  level; aborts any activity.
REQ-009 SHALL have port prn_in  in  5  requested satellite PRN, 1..32.
REQ-010 SHALL have port sample_valid  in  1  one input sample this cycle.
REQ-011 SHALL have port corr_p_pow  in  32  unsigned punctual I²+Q² power, valid in the cycle after dump.
REQ-012 SHALL have port corr_noise  in  32  unsigned noise-floor estimate, valid with corr_p_pow.
REQ-013 SHALL have port dump  out  1  one-cycle epoch-end pulse to the correlators.
REQ-014 SHALL have port code_step  out  1  one-cycle pulse; code generator slips half a chip.
REQ-015 SHALL have port prn_select  out  5  PRN latched for the code generator.
REQ-016 SHALL have port loop_en  out  1  enables DLL/Costas correction updates.
REQ-017 SHALL have port locked  out  1  high only in TRACK.
REQ-018 SHALL have port fail  out  1  high only in FAIL.
REQ-019 SHALL have port state  out  3  IDLE=0, SEARCH=1, PULL_IN=2, TRACK=3, FAIL=4.

Function
REQ-020 SHALL count sample_valid cycles in a 16-bit epoch counter, active outside IDLE, wrapping from EPOCH_LEN-1 to 0.
REQ-021 SHALL register dump high for exactly one cycle in the cycle after a sample_valid at count EPOCH_LEN-1.
REQ-022 SHALL evaluate hit = corr_p_pow > (corr_noise << THRESH_SHIFT), computed at 40-bit width without truncation, one cycle after dump ("eval cycle").
REQ-023 IDLE: outputs low; start with prn_in in 1..32 latches prn_select, clears epoch, step and window counters, enters SEARCH; prn_in 0 is ignored.
REQ-024 SEARCH: on an eval cycle, hit -> PULL_IN; miss -> pulse code_step in that cycle and increment the 11-bit step counter.
REQ-025 SEARCH: a miss when the step counter already holds 2045 (2046 half-chip cells searched) -> FAIL with no code_step.
REQ-026 PULL_IN: loop_en high; count eval cycles and hits; after PI_EPOCHS evaluations, hits >= PI_EPOCHS/2 (integer) -> TRACK, else -> SEARCH with one code_step and step counter incremented.
REQ-027 TRACK: loop_en and locked high; a miss increments the miss counter, a hit clears it; reaching LOSS_EPOCHS -> SEARCH with the step counter cleared.
REQ-028 FAIL: fail held high; start (edge not required) -> SEARCH with counters cleared and prn_in re-latched.
REQ-029 stop high in any state -> IDLE on the next edge; stop has priority over start and over all eval transitions.
REQ-030 start while in SEARCH, PULL_IN or TRACK SHALL be ignored; prn_select SHALL change only on entry from IDLE or FAIL.
REQ-031 The epoch counter SHALL continue uninterrupted across SEARCH/PULL_IN/TRACK transitions.

Reset
REQ-032 RST SHALL asynchronously force state IDLE, all counters 0, prn_select 0, and dump, code_step, loop_en, locked and fail low.

Configuration
REQ-033 With TRACK_CTRL_STATS_EN defined, SHALL add output lock_epochs (32) counting eval cycles spent in TRACK, saturating at 0xFFFFFFFF, cleared on entry from IDLE or FAIL; without it the port and counter SHALL be absent.

Verification
REQ-034 EPOCH_LEN=4, sample_valid constant -> dump every 4th cycle, first dump 5 cycles after reset release plus start.
REQ-035 SEARCH, always miss -> 2045 code_step pulses, then FAIL with fail=1, state=4.
REQ-036 corr_noise=100, corr_p_pow=801 on the 3rd eval -> exactly 2 code_steps, then PULL_IN; pow=800 counts as miss.
REQ-037 PULL_IN with PI_EPOCHS=20 and 10 hits -> TRACK and locked=1; 9 hits -> SEARCH with one code_step.
REQ-038 TRACK, LOSS_EPOCHS=50, 49 misses, one hit, 50 misses -> SEARCH only after the final 50th miss.
REQ-039 stop and a hit eval in the same cycle during TRACK -> IDLE; RST mid-SEARCH -> all outputs 0 immediately.
